// File: rtl/output_port_arbiter_if.sv
// Arbiter-side bundle: input queue heads/pops, route requests, downstream link and counter.
`ifndef PL
`define PL 8
`endif

interface output_port_arbiter_if #(
  parameter int unsigned N      = 5,
  parameter int unsigned FLIT_W = `PL
);
  logic [N*FLIT_W-1:0] in_data;
  logic [N-1:0]        in_req;
  logic [N-1:0]        in_shift;
  logic [FLIT_W-1:0]   out_data;
  logic                out_avail;
  logic [15:0]         pkt_count;

  modport master (
    input  in_data, in_req, out_avail,
    output in_shift, out_data, pkt_count
  );

  modport slave (
    output in_data, in_req, out_avail,
    input  in_shift, out_data, pkt_count
  );
endinterface

// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: round-robin on head flits, locked to one input until its tail.
// Optional packet counter enabled by defining ARB_PKT_COUNT_EN.
`ifndef PL
`define PL 8
`endif

module output_port_arbiter #(
  parameter int unsigned N      = 5,
  parameter int unsigned FLIT_W = `PL
) (
  input logic                   clk,
  input logic                   rst_n,
  output_port_arbiter_if.master bus
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;
  typedef logic [1:0] ftype_t;

  // Type field is bits [1:2], bit 1 being the MSB of the code.
  localparam ftype_t TyBody = 2'b00;
  localparam ftype_t TyHead = 2'b01;

  function automatic ftype_t flit_type(input logic [FLIT_W-1:0] f);
    return {f[1], f[2]};
  endfunction

  state_e            state_q, state_d;
  logic [FLIT_W-1:0] out_q, out_d;
  logic [PtrW-1:0]   rr_q, rr_d;
  logic [PtrW-1:0]   owner_q, owner_d;
  logic [PtrW-1:0]   win;
  logic              win_found;
  logic              slot_free;
  logic              xfer;
  logic [N-1:0]      shift;
  logic [FLIT_W-1:0] flits [N];

  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      flits[k] = bus.in_data[k*FLIT_W +: FLIT_W];
    end
  end

  assign xfer      = out_q[0] & bus.out_avail;
  assign slot_free = ~out_q[0] | bus.out_avail;

  // First candidate at or after rr_q; head and single both have bit 2 set.
  always_comb begin : rr_search
    int unsigned     idx;
    logic [PtrW-1:0] cur;
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    cur       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= N) idx = idx - N;
      cur = PtrW'(idx);
      if (!win_found && flits[cur][0] && flits[cur][2] && bus.in_req[cur]) begin
        win_found = 1'b1;
        win       = cur;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = xfer ? '0 : out_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    shift   = '0;
    case (state_q)
      StIdle: begin
        if (slot_free && win_found) begin
          out_d      = flits[win];
          shift[win] = 1'b1;
          owner_d    = win;
          rr_d       = (win == PtrW'(N - 1)) ? '0 : win + 1'b1;
          if (flit_type(flits[win]) == TyHead) state_d = StLocked;
        end
      end
      StLocked: begin
        if (slot_free && flits[owner_q][0]) begin
          out_d          = flits[owner_q];
          shift[owner_q] = 1'b1;
          // Anything but a body ends the packet, including a stray head/single.
          if (flit_type(flits[owner_q]) != TyBody) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      out_q   <= '0;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  // Pop strobe is combinational; block it while reset is held.
  assign bus.in_shift = rst_n ? shift : '0;
  assign bus.out_data = out_q;

`ifdef ARB_PKT_COUNT_EN
  logic [15:0] cnt_q;

  // Tail (10) and single (11) both carry bit 1 set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (xfer && out_q[1]) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.pkt_count = cnt_q;
`else
  assign bus.pkt_count = '0;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: input queues modelled as arrays, downstream as a log.
module tb_output_port_arbiter;

  localparam int unsigned N  = 5;
  localparam int unsigned FW = 8;
  localparam logic [1:0] TH = 2'b01;
  localparam logic [1:0] TB = 2'b00;
  localparam logic [1:0] TT = 2'b10;
  localparam logic [1:0] TS = 2'b11;
`ifdef ARB_PKT_COUNT_EN
  localparam logic [15:0] EXP_PKTS = 16'd3;
`else
  localparam logic [15:0] EXP_PKTS = 16'd0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  output_port_arbiter_if #(.N(N), .FLIT_W(FW)) bus ();

  output_port_arbiter #(.N(N), .FLIT_W(FW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [FW-1:0] qmem [N][16];
  int            rd_p [N];
  int            wr_p [N];
  logic [FW-1:0] log_q [64];
  int            n_log;
  logic [N-1:0]  sh_s;

  function automatic logic [FW-1:0] fl(input logic [1:0] t, input logic [4:0] pl);
    return {pl, t[0], t[1], 1'b1};
  endfunction

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      bus.in_data[k*FW +: FW] = (rd_p[k] < wr_p[k]) ? qmem[k][rd_p[k]] : '0;
    end
  endtask

  task automatic push(input int k, input logic [FW-1:0] f);
    qmem[k][wr_p[k]] = f;
    wr_p[k]++;
    drive_inputs();
  endtask

  task automatic clear_queues();
    for (int k = 0; k < N; k++) begin
      rd_p[k] = 0;
      wr_p[k] = 0;
    end
    n_log = 0;
    drive_inputs();
  endtask

  // One clock: sample pops/transfers at negedge, apply pops after the edge.
  task automatic tick();
    @(negedge clk);
    sh_s = bus.in_shift;
    if (bus.out_data[0] && bus.out_avail) begin
      log_q[n_log] = bus.out_data;
      n_log++;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (sh_s[k] && rd_p[k] < wr_p[k]) rd_p[k]++;
    end
    drive_inputs();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.in_req = '0;
    bus.out_avail = 1'b1;
    clear_queues();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_avail = 1'b1;
    clear_queues();
    push(0, fl(TS, 5'd1));
    bus.in_req = 5'b00001;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_out: got %h expected %h", bus.out_data, 8'h00);
    end
    n_cmp++;
    if (bus.in_shift !== 5'b00000) begin
      n_fail++; $display("FAIL reset_shift: got %b expected %b", bus.in_shift, 5'b00000);
    end
    n_cmp++;
    if (bus.pkt_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bus.pkt_count);
    end
  endtask

  task automatic test_single();
    apply_reset();
    push(2, fl(TS, 5'd5));
    bus.in_req = 5'b00100;
    #1;
    n_cmp++;
    if (bus.in_shift !== 5'b00100) begin
      n_fail++; $display("FAIL single_shift: got %b expected %b", bus.in_shift, 5'b00100);
    end
    tick();
    n_cmp++;
    if (bus.out_data !== fl(TS, 5'd5)) begin
      n_fail++; $display("FAIL single_out: got %h expected %h", bus.out_data, fl(TS, 5'd5));
    end
    n_cmp++;
    if (bus.in_shift !== 5'b00000) begin
      n_fail++; $display("FAIL single_one_pulse: got %b expected %b", bus.in_shift, 5'b00000);
    end
    push(0, fl(TS, 5'd6));
    bus.in_req = 5'b00101;
    #1;
    n_cmp++;
    if (bus.in_shift !== 5'b00001) begin
      n_fail++; $display("FAIL single_stays_idle: got %b expected %b", bus.in_shift, 5'b00001);
    end
    tick();
    n_cmp++;
    if (bus.out_data !== fl(TS, 5'd6)) begin
      n_fail++; $display("FAIL single_out2: got %h expected %h", bus.out_data, fl(TS, 5'd6));
    end
    tick();
    n_cmp++;
    if (n_log !== 2 || log_q[0] !== fl(TS, 5'd5)) begin
      n_fail++; $display("FAIL single_xfers: got %0d/%h expected 2/%h", n_log, log_q[0], fl(TS, 5'd5));
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    push(0, fl(TS, 5'd1));
    push(3, fl(TS, 5'd2));
    bus.in_req = 5'b01001;
    #1;
    n_cmp++;
    if (bus.in_shift !== 5'b00001) begin
      n_fail++; $display("FAIL rr_first: got %b expected %b", bus.in_shift, 5'b00001);
    end
    tick();
    n_cmp++;
    if (bus.out_data !== fl(TS, 5'd1) || bus.in_shift !== 5'b01000) begin
      n_fail++; $display("FAIL rr_second: got %h/%b expected %h/%b", bus.out_data, bus.in_shift,
                         fl(TS, 5'd1), 5'b01000);
    end
    tick();
    n_cmp++;
    if (bus.out_data !== fl(TS, 5'd2) || bus.in_shift !== 5'b00000) begin
      n_fail++; $display("FAIL rr_third_out: got %h/%b expected %h/%b", bus.out_data, bus.in_shift,
                         fl(TS, 5'd2), 5'b00000);
    end
    push(1, fl(TS, 5'd3));
    push(4, fl(TS, 5'd4));
    bus.in_req = 5'b10010;
    #1;
    n_cmp++;
    if (bus.in_shift !== 5'b10000) begin
      n_fail++; $display("FAIL rr_ptr_at_4: got %b expected %b", bus.in_shift, 5'b10000);
    end
    tick();
    n_cmp++;
    if (bus.in_shift !== 5'b00010) begin
      n_fail++; $display("FAIL rr_wrap_to_1: got %b expected %b", bus.in_shift, 5'b00010);
    end
    tick();
    tick();
  endtask

  task automatic test_wormhole();
    logic [N-1:0]  exp_sh  [8];
    logic [FW-1:0] exp_out [8];
    apply_reset();
    push(1, fl(TH, 5'd1));
    push(1, fl(TB, 5'd2));
    push(1, fl(TB, 5'd3));
    push(1, fl(TT, 5'd4));
    push(4, fl(TH, 5'd9));
    push(4, fl(TT, 5'd10));
    bus.in_req = 5'b10010;
    #1;
    exp_sh[0] = 5'b00010; exp_out[0] = fl(TH, 5'd1);
    exp_sh[1] = 5'b00010; exp_out[1] = fl(TB, 5'd2);
    exp_sh[2] = 5'b00010; exp_out[2] = fl(TB, 5'd3);
    exp_sh[3] = 5'b00010; exp_out[3] = fl(TT, 5'd4);
    exp_sh[4] = 5'b10000; exp_out[4] = fl(TH, 5'd9);
    exp_sh[5] = 5'b10000; exp_out[5] = fl(TT, 5'd10);
    exp_sh[6] = 5'b00000; exp_out[6] = 8'h00;
    exp_sh[7] = 5'b00000; exp_out[7] = 8'h00;
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if (bus.in_shift !== exp_sh[c]) begin
        n_fail++; $display("FAIL worm_shift[%0d]: got %b expected %b", c, bus.in_shift, exp_sh[c]);
      end
      tick();
      n_cmp++;
      if (bus.out_data !== exp_out[c]) begin
        n_fail++; $display("FAIL worm_out[%0d]: got %h expected %h", c, bus.out_data, exp_out[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    push(0, fl(TH, 5'd1));
    push(0, fl(TB, 5'd2));
    push(0, fl(TT, 5'd3));
    bus.in_req = 5'b00001;
    #1;
    tick();
    n_cmp++;
    if (bus.out_data !== fl(TH, 5'd1)) begin
      n_fail++; $display("FAIL bp_head: got %h expected %h", bus.out_data, fl(TH, 5'd1));
    end
    for (int i = 0; i < 5; i++) begin
      bus.out_avail = 1'b0;
      #1;
      n_cmp++;
      if (bus.out_data !== fl(TH, 5'd1) || bus.in_shift !== 5'b00000) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got %h/%b expected %h/%b", i, bus.out_data,
                           bus.in_shift, fl(TH, 5'd1), 5'b00000);
      end
      tick();
    end
    bus.out_avail = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_shift !== 5'b00001 || n_log !== 0) begin
      n_fail++; $display("FAIL bp_release: got %b/%0d expected %b/0", bus.in_shift, n_log, 5'b00001);
    end
    tick();
    n_cmp++;
    if (bus.out_data !== fl(TB, 5'd2) || n_log !== 1 || log_q[0] !== fl(TH, 5'd1)) begin
      n_fail++; $display("FAIL bp_same_cycle: got %h/%0d expected %h/1", bus.out_data, n_log,
                         fl(TB, 5'd2));
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if (n_log !== 3 || log_q[2] !== fl(TT, 5'd3)) begin
      n_fail++; $display("FAIL bp_drain: got %0d/%h expected 3/%h", n_log, log_q[2], fl(TT, 5'd3));
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    push(2, fl(TH, 5'd1));
    push(2, fl(TB, 5'd2));
    push(2, fl(TT, 5'd3));
    bus.in_req = 5'b00100;
    #1;
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_data !== 8'h00 || bus.in_shift !== 5'b00000) begin
      n_fail++; $display("FAIL rstmid_clear: got %h/%b expected 00/%b", bus.out_data, bus.in_shift,
                         5'b00000);
    end
    @(posedge clk);
    #1;
    push(1, fl(TS, 5'd7));
    push(4, fl(TS, 5'd8));
    bus.in_req = 5'b10110;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_data !== 8'h00) begin
      n_fail++; $display("FAIL rstmid_no_partial: got %h expected %h", bus.out_data, 8'h00);
    end
    n_cmp++;
    if (bus.in_shift !== 5'b00010) begin
      n_fail++; $display("FAIL rstmid_rr0: got %b expected %b", bus.in_shift, 5'b00010);
    end
    tick();
    n_cmp++;
    if (bus.out_data !== fl(TS, 5'd7)) begin
      n_fail++; $display("FAIL rstmid_grant: got %h expected %h", bus.out_data, fl(TS, 5'd7));
    end
    tick();
    tick();
  endtask

  task automatic test_pkt_count();
    apply_reset();
    push(0, fl(TS, 5'd1));
    push(1, fl(TH, 5'd2));
    push(1, fl(TT, 5'd3));
    push(3, fl(TS, 5'd4));
    bus.in_req = 5'b01011;
    #1;
    repeat (8) tick();
    n_cmp++;
    if (n_log !== 4 || log_q[3] !== fl(TS, 5'd4)) begin
      n_fail++; $display("FAIL cnt_stream: got %0d/%h expected 4/%h", n_log, log_q[3], fl(TS, 5'd4));
    end
    n_cmp++;
    if (bus.pkt_count !== EXP_PKTS) begin
      n_fail++; $display("FAIL cnt_value: got %0d expected %0d", bus.pkt_count, EXP_PKTS);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.pkt_count !== 16'd0) begin
      n_fail++; $display("FAIL cnt_reset: got %0d expected 0", bus.pkt_count);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_req    = '0;
    bus.out_avail = 1'b1;
    bus.in_data   = '0;
    n_log         = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_wormhole();
    test_backpressure();
    test_reset_mid();
    test_pkt_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
